// File: rtl/booth_seq_ctrl_if.sv
// Operand/result handshake bundle for booth_seq_ctrl.
// The master supplies operands and consumes the product; the slave is the multiplier.
interface booth_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Sequential 16x16 radix-2 Booth multiplier: 17 RUN cycles per product, held until taken.
// Define BOOTH_SIGNED_EN for two's-complement operands; unsigned by default.
module booth_seq_ctrl (
    input  logic                 clk,
    input  logic                 rst_n,
    booth_seq_ctrl_if.slave      bus,
    output logic                 busy,
    output logic [15:0]          op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [16:0] acc;
    logic [16:0] mq;
    logic [16:0] mm;
    logic        q_m1;
    logic [4:0]  iter;

    logic [16:0] ext_a;
    logic [16:0] ext_b;
    logic [16:0] sum;
    logic [16:0] acc_sh;
    logic [16:0] q_sh;

`ifdef BOOTH_SIGNED_EN
    assign ext_a = {bus.a[15], bus.a};
    assign ext_b = {bus.b[15], bus.b};
`else
    assign ext_a = {1'b0, bus.a};
    assign ext_b = {1'b0, bus.b};
`endif

    // One Booth step followed by the arithmetic shift of {A,Q,Q_-1}.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        sum = acc;
        case ({mq[0], q_m1})
            2'b01:   sum = acc + mm;
            2'b10:   sum = acc - mm;
            default: sum = acc;
        endcase
        acc_sh = {sum[16], sum[16:1]};
        q_sh   = {sum[0], mq[16:1]};
    end

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            mq            <= '0;
            mm            <= '0;
            q_m1          <= 1'b0;
            iter          <= '0;
            op_count      <= '0;
            bus.result    <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mm           <= ext_a;
                        mq           <= ext_b;
                        acc          <= '0;
                        q_m1         <= 1'b0;
                        iter         <= '0;
                        state        <= RUN;
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                RUN: begin
                    acc  <= acc_sh;
                    mq   <= q_sh;
                    q_m1 <= mq[0];
                    iter <= iter + 5'd1;
                    // Last of 17 steps: the shifted values are the final {A,Q}.
                    if (iter == 5'd16) begin
                        state         <= HOLD;
                        busy          <= 1'b0;
                        bus.out_valid <= 1'b1;
                        bus.result    <= {acc_sh[14:0], q_sh};
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        op_count      <= op_count + 16'd1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl: latency/handshake model plus literal product checks.
// Honours BOOTH_SIGNED_EN the same way as the design.
module tb_booth_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic [15:0] op_count;

    booth_seq_ctrl_if bus ();

    booth_seq_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] prod(input logic [15:0] x, input logic [15:0] y);
        longint p;
`ifdef BOOTH_SIGNED_EN
        p = longint'($signed(x)) * longint'($signed(y));
`else
        p = longint'(x) * longint'(y);
`endif
        return p[31:0];
    endfunction

    // Model: cycles left until the product appears (-1 idle, 0 holding a product).
    int          left  = -1;
    logic [31:0] m_res = '0;
    logic [31:0] m_pend = '0;
    logic [15:0] m_cnt = '0;
    bit          armed = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            left  = -1;
            m_res = '0;
            m_cnt = '0;
            armed = 1'b1;
        end else if (armed) begin
            if (left < 0) begin
                if (bus.in_valid) begin
                    left   = 17;
                    m_pend = prod(bus.a, bus.b);
                end
            end else if (left > 0) begin
                left--;
                if (left == 0) m_res = m_pend;
            end else if (bus.out_ready) begin
                left  = -1;
                m_cnt = m_cnt + 16'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("in_ready",  {31'd0, bus.in_ready},  {31'd0, left < 0});
            check("busy",      {31'd0, busy},          {31'd0, left > 0});
            check("out_valid", {31'd0, bus.out_valid}, {31'd0, left == 0});
            check("result",    bus.result,             m_res);
            check("op_count",  {16'd0, op_count},      {16'd0, m_cnt});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] x, input logic [15:0] y);
        int k = 0;
        while (!bus.in_ready && k < 50) begin
            tick();
            k++;
        end
        check("accept_wait", {31'd0, bus.in_ready}, 32'd1);
        bus.a        = x;
        bus.b        = y;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Called right after the accept edge; checks latency, literal product, stall, drain.
    task automatic finish_op(input logic [31:0] expv, input int stall, input bit early);
        int k = 0;
        if (early) bus.out_ready = 1'b1;
        do begin
            tick();
            k++;
        end while (!bus.out_valid && k < 40);
        check("latency", k, 32'd17);
        check("product", bus.result, expv);
        if (!early) begin
            for (int i = 0; i < stall; i++) begin
                tick();
                check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
                check("stall_ready", {31'd0, bus.in_ready}, 32'd0);
                check("stall_result", bus.result, expv);
            end
            bus.out_ready = 1'b1;
        end
        tick();
        bus.out_ready = 1'b0;
        check("idle_after", {31'd0, bus.in_ready}, 32'd1);
        check("drained", {31'd0, bus.out_valid}, 32'd0);
    endtask

    task automatic op(input logic [15:0] x, input logic [15:0] y, input logic [31:0] expv,
                      input int stall, input bit early);
        accept(x, y);
        finish_op(expv, stall, early);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_result", bus.result, 32'd0);
        check("rst_op_count", {16'd0, op_count}, 32'd0);

        // Abort at iteration 8, then a clean product.
        accept(16'd100, 16'd200);
        repeat (8) tick();
        check("abort_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_idle", {31'd0, bus.in_ready}, 32'd1);
        check("abort_result", bus.result, 32'd0);
        check("abort_count", {16'd0, op_count}, 32'd0);
        op(16'd7, 16'd6, 32'd42, 0, 1'b0);
        check("count_after_42", {16'd0, op_count}, 32'd1);

        op(16'd3, 16'd5, 32'd15, 0, 1'b1);
        op(16'd0, 16'h1234, 32'd0, 0, 1'b0);
`ifdef BOOTH_SIGNED_EN
        op(16'hFFFF, 16'hFFFF, 32'h0000_0001, 5, 1'b0);
        op(16'h8000, 16'h0002, 32'hFFFF_0000, 0, 1'b1);
        op(16'h8000, 16'h8000, 32'h4000_0000, 0, 1'b0);
        op(16'h7FFF, 16'h8000, 32'hC000_8000, 0, 1'b0);
`else
        op(16'h7FFF, 16'h7FFF, 32'h3FFF_0001, 5, 1'b0);
        op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0, 1'b1);
        op(16'h8000, 16'h8000, 32'h4000_0000, 0, 1'b0);
        op(16'hFFFF, 16'h0001, 32'h0000_FFFF, 0, 1'b0);
`endif

        // in_valid held through RUN with new operands: ignored until IDLE.
        bus.a        = 16'd3;
        bus.b        = 16'd5;
        bus.in_valid = 1'b1;
        tick();
        bus.a        = 16'd9;
        bus.b        = 16'd11;
        finish_op(32'd15, 2, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        check("second_busy", {31'd0, busy}, 32'd1);
        finish_op(32'd99, 0, 1'b0);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
